lookupflow_req: RTL and testbench

Requester (initiator) side of the flow-lookup handshake. Assembles a 96-bit tuple (destination MAC, source MAC) from the first 12 header bytes of each received frame. Issues `req`/`tuple` to the lookup responder, waits for `ack`, and captures `fwd_port`. Returns the forwarding decision to the port's forwarding logic, with a timeout fallback and a drop counter. It sits in each port's receive path, in front of the lookup responder.

---
 rtl/lookupflow_req.sv | 145 ++++++++++++++
 tb/tb_lookupflow_req.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lookupflow_req.sv
// Flow-lookup requester: collects the 12-byte MAC tuple from each received frame,
// runs the req/ack handshake with the responder and reports the forwarding decision.
module lookupflow_req #(
  parameter int          TIMEOUT      = 16,
  parameter logic [3:0]  DEFAULT_PORT = 4'b1110
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic [7:0]  rx_data,
  output logic        req,
  output logic [95:0] tuple,
  input  logic        ack,
  input  logic [3:0]  fwd_port,
  output logic        res_valid,
  output logic [3:0]  res_port,
  output logic        res_timeout,
  output logic [15:0] drop_cnt
);

  // state   | meaning
  // IDLE    | no lookup outstanding; issue one as soon as a tuple is pending
  // REQ     | req high, tuple stable, waiting for ack or timer expiry
  // RELEASE | decision reported; wait for the responder to drop ack
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t       state;
  logic [3:0]   idx;
  logic [95:0]  collect;
  logic [95:0]  collect_nxt;
  logic [95:0]  pend_buf;
  logic         pending;
  logic [7:0]   timer;
  logic         complete;
  logic         short_frame;
  logic         take;
  logic         overrun;

  always_comb begin
    collect_nxt = collect;
    if (rx_valid) begin
      if (rx_sof) begin
        collect_nxt[95:88] = rx_data;
      end else begin
        for (int i = 0; i < 12; i++) begin
          if (idx == 4'(i)) collect_nxt[95-8*i -: 8] = rx_data;
        end
      end
    end
  end

  // An SOF byte always lands in slot 0, so it can never complete a tuple.
  assign complete    = rx_valid & ~rx_sof & (idx == 4'd11);
  assign short_frame = rx_valid & rx_eof & (rx_sof | (idx < 4'd11));
  assign take        = (state == IDLE) & pending;
  assign overrun     = complete & pending & ~take;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx     <= 4'd0;
      collect <= 96'd0;
    end else begin
      collect <= collect_nxt;
      if (rx_valid) begin
        if (rx_sof)              idx <= 4'd1;
        else if (idx < 4'd12)    idx <= idx + 4'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pending  <= 1'b0;
      pend_buf <= 96'd0;
    end else if (complete && (!pending || take)) begin
      pending  <= 1'b1;
      pend_buf <= collect_nxt;
    end else if (take) begin
      pending  <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      drop_cnt <= 16'd0;
    end else if ((short_frame || overrun) && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      req         <= 1'b0;
      tuple       <= 96'd0;
      timer       <= 8'd0;
      res_valid   <= 1'b0;
      res_port    <= 4'd0;
      res_timeout <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          req <= 1'b0;
          if (pending) begin
            tuple <= pend_buf;
            timer <= 8'd0;
            req   <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            res_port    <= fwd_port;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            req         <= 1'b0;
            state       <= RELEASE;
          end else if (timer == TIMER_LAST) begin
            res_port    <= DEFAULT_PORT;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            req         <= 1'b0;
            state       <= RELEASE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RELEASE: begin
          req <= 1'b0;
          if (!ack) state <= IDLE;
        end
        default: begin
          req   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lookupflow_req.sv
// Bench for lookupflow_req: frame driver, configurable responder, and a monitor
// that scores each lookup against the expected tuple/decision queue.
module tb_lookupflow_req;

  logic        sys_clk, sys_rst;
  logic        rx_valid, rx_sof, rx_eof;
  logic [7:0]  rx_data;
  logic        req, ack;
  logic [95:0] tuple;
  logic [3:0]  fwd_port;
  logic        res_valid, res_timeout;
  logic [3:0]  res_port;
  logic [15:0] drop_cnt;

  lookupflow_req #(.TIMEOUT(16), .DEFAULT_PORT(4'b1110)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_data(rx_data),
    .req(req), .tuple(tuple), .ack(ack), .fwd_port(fwd_port),
    .res_valid(res_valid), .res_port(res_port), .res_timeout(res_timeout),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [95:0] tup;
    logic [3:0]  port;
    logic        tmo;
    int          lat;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   rise_cyc = 0, rise_gap = 0, last_ack_cyc = -100, byte_cyc = 0;
  logic in_flight = 1'b0, prev_req = 1'b0;

  // responder configuration
  logic       ack_en = 1'b1;
  int         ack_delay = 1, ack_hold = 0;
  logic [3:0] resp_port = 4'd0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Responder: ack appears ack_delay cycles after req rises, then may linger ack_hold cycles after req drops.
  initial begin
    logic r;
    int   cnt, hold;
    cnt = 0; hold = 0;
    ack = 1'b0; fwd_port = 4'd0;
    forever begin
      @(negedge sys_clk);
      r = req;
      @(posedge sys_clk);
      #1;
      if (r) cnt++; else cnt = 0;
      if (ack_en && r && cnt >= ack_delay) begin
        ack = 1'b1;
        hold = ack_hold;
      end else if (ack && hold > 0) begin
        hold--;
      end else begin
        ack = 1'b0;
      end
      fwd_port = resp_port;
    end
  end

  // Monitor: pops an expectation at each req rise and scores the matching res_valid.
  initial forever begin
    @(negedge sys_clk);
    if (sys_rst) begin
      in_flight = 1'b0;
      prev_req  = 1'b0;
    end else begin
      if (req && !prev_req) begin
        rise_cyc = cyc;
        rise_gap = cyc - last_ack_cyc;
        chk("ack_gap_ok", 96'(rise_gap >= 3), 96'd1);
        chk("req_expected", 96'(q.size() != 0), 96'd1);
        if (q.size() != 0) begin
          cur = q.pop_front();
          in_flight = 1'b1;
          chk("tuple", tuple, cur.tup);
        end
      end else if (req && in_flight) begin
        chk("tuple_hold", tuple, cur.tup);
      end
      if (res_valid) begin
        chk("res_expected", 96'(in_flight), 96'd1);
        if (in_flight) begin
          chk("res_latency", 96'(cyc - rise_cyc), 96'(cur.lat));
          chk("res_port", 96'(res_port), 96'(cur.port));
          chk("res_timeout", 96'(res_timeout), 96'(cur.tmo));
          chk("req_fall", 96'(req), 96'd0);
          in_flight = 1'b0;
        end
      end
      if (ack) last_ack_cyc = cyc;
      prev_req = req;
    end
  end

  task automatic expect_lookup(input logic [95:0] tup);
    exp_t e;
    e.tup = tup;
    if (ack_en) begin
      e.port = resp_port; e.tmo = 1'b0; e.lat = ack_delay + 1;
    end else begin
      e.port = 4'b1110; e.tmo = 1'b1; e.lat = 16;
    end
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [95:0] hdr, input int len, input logic with_eof);
    for (int i = 0; i < len; i++) begin
      @(posedge sys_clk);
      #1;
      rx_valid = 1'b1;
      rx_sof   = (i == 0);
      rx_eof   = with_eof && (i == len - 1);
      rx_data  = (i < 12) ? hdr[95-8*i -: 8] : 8'($urandom_range(0, 255));
      if (i == 11) byte_cyc = cyc;
    end
  endtask

  task automatic rx_idle();
    @(posedge sys_clk);
    #1;
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || in_flight) && n < budget) begin
      @(posedge sys_clk);
      n++;
    end
    chk("drain_in_time", 96'(n < budget), 96'd1);
    repeat (20) @(posedge sys_clk);
  endtask

  function automatic logic [95:0] rand_hdr();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [95:0] h1, h2, h3;
    int n;
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'd0;
    sys_rst = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_req", 96'(req), 96'd0);
    chk("rst_tuple", tuple, 96'd0);
    chk("rst_res_valid", 96'(res_valid), 96'd0);
    chk("rst_res_port", 96'(res_port), 96'd0);
    chk("rst_res_timeout", 96'(res_timeout), 96'd0);
    chk("rst_drop_cnt", 96'(drop_cnt), 96'd0);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);

    // basic lookup, 1-cycle responder
    ack_en = 1'b1; ack_delay = 1; ack_hold = 0; resp_port = 4'b0010;
    h1 = 96'h001e4f498191_000000000003;
    expect_lookup(h1);
    send_frame(h1, 14, 1'b1); rx_idle();
    drain(100);
    chk("req_latency", 96'(rise_cyc - byte_cyc), 96'd2);
    chk("res_port_held", 96'(res_port), 96'b0010);

    // timeout
    ack_en = 1'b0;
    h1 = rand_hdr();
    expect_lookup(h1);
    send_frame(h1, 12, 1'b1); rx_idle();
    drain(100);
    chk("timeout_port_held", 96'(res_port), 96'b1110);
    chk("timeout_flag_held", 96'(res_timeout), 96'd1);

    // short frame, then a long frame; then a restart by mid-frame SOF
    ack_en = 1'b1; ack_delay = 2; resp_port = 4'b0101;
    send_frame(rand_hdr(), 8, 1'b1); rx_idle();
    repeat (10) @(posedge sys_clk);
    chk("short_drop", 96'(drop_cnt), 96'd1);
    h1 = rand_hdr();
    expect_lookup(h1);
    send_frame(h1, 60, 1'b1); rx_idle();
    drain(100);
    h1 = rand_hdr();
    expect_lookup(h1);
    send_frame(rand_hdr(), 5, 1'b0);
    send_frame(h1, 20, 1'b1); rx_idle();
    drain(100);
    chk("restart_no_drop", 96'(drop_cnt), 96'd1);

    // back-to-back frames: second pends, third overruns
    ack_delay = 10; ack_hold = 15; resp_port = 4'b1001;
    h1 = rand_hdr(); h2 = rand_hdr(); h3 = rand_hdr();
    expect_lookup(h1);
    expect_lookup(h2);
    send_frame(h1, 12, 1'b1);
    send_frame(h2, 12, 1'b1);
    send_frame(h3, 12, 1'b1); rx_idle();
    drain(300);
    chk("overrun_drop", 96'(drop_cnt), 96'd2);
    chk("b2b_release_gap", 96'(rise_gap), 96'd3);

    // ack lingering 3 cycles after req falls
    ack_delay = 8; ack_hold = 3; resp_port = 4'b0011;
    h1 = rand_hdr(); h2 = rand_hdr();
    expect_lookup(h1);
    expect_lookup(h2);
    send_frame(h1, 12, 1'b1);
    send_frame(h2, 12, 1'b1); rx_idle();
    drain(200);
    chk("hold_release_gap", 96'(rise_gap), 96'd3);
    chk("hold_no_drop", 96'(drop_cnt), 96'd2);

    // asynchronous reset during REQ
    ack_en = 1'b0; ack_hold = 0;
    h1 = rand_hdr();
    expect_lookup(h1);
    send_frame(h1, 12, 1'b1); rx_idle();
    n = 0;
    while (!req && n < 50) begin
      @(posedge sys_clk);
      n++;
    end
    chk("req_seen_before_rst", 96'(req), 96'd1);
    repeat (3) @(posedge sys_clk);
    #3 sys_rst = 1'b1;
    #1;
    chk("arst_req", 96'(req), 96'd0);
    chk("arst_tuple", tuple, 96'd0);
    chk("arst_res_valid", 96'(res_valid), 96'd0);
    chk("arst_res_port", 96'(res_port), 96'd0);
    chk("arst_drop_cnt", 96'(drop_cnt), 96'd0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (25) @(posedge sys_clk);
    ack_en = 1'b1; ack_delay = 1; resp_port = 4'b0100;
    h1 = rand_hdr();
    expect_lookup(h1);
    send_frame(h1, 12, 1'b1); rx_idle();
    drain(100);
    chk("post_rst_drop_cnt", 96'(drop_cnt), 96'd0);
    chk("post_rst_port", 96'(res_port), 96'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
